dbus_demux: RTL and testbench

Data-bus demultiplexer between the CPU memory stage and two data-side targets: data RAM on port 0 and memory-mapped I/O on port 1. Each CPU access is decoded by address, forwarded to exactly one target under a req/ack handshake, and returned to the CPU with registered read data. Its job is the reverse of the datapath selectors: one source fanned out to several destinations. It also adds wait-state tracking, a timeout and alignment checking.

---
 rtl/dbus_demux.sv | 170 +++++++++++++++++
 tb/tb_dbus_demux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_demux.sv
// dbus_demux: fans one CPU data-bus access out to data RAM (port 0) or MMIO (port 1).
// Every access is decoded by address and forwarded under req/ack. The result comes back to the
// CPU as a registered one-cycle ack. Misaligned accesses and target timeouts complete with err.
module dbus_demux #(
    parameter logic [3:0]  IO_NIBBLE = 4'hF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,

    output logic        s0_req,
    output logic        s0_we,
    output logic [31:0] s0_addr,
    output logic [31:0] s0_wdata,
    input  logic [31:0] s0_rdata,
    input  logic        s0_ack,

    output logic        s1_req,
    output logic        s1_we,
    output logic [31:0] s1_addr,
    output logic [31:0] s1_wdata,
    input  logic [31:0] s1_rdata,
    input  logic        s1_ack
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);
    localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;

    logic [31:0] rdata_d;
    logic        ack_d, err_d;
    logic        s0_req_d, s0_we_d, s1_req_d, s1_we_d;
    logic [31:0] s0_addr_d, s0_wdata_d, s1_addr_d, s1_wdata_d;

    // Target-side views of the selected port.
    logic        tgt_ack;
    logic [31:0] tgt_rdata;
    logic        tgt_we;

    assign tgt_ack   = sel_q ? s1_ack   : s0_ack;
    assign tgt_rdata = sel_q ? s1_rdata : s0_rdata;
    assign tgt_we    = sel_q ? s1_we    : s0_we;

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        rdata_d    = rdata;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        // Target ports are idle unless an access is in flight.
        s0_req_d   = 1'b0;
        s0_we_d    = 1'b0;
        s0_addr_d  = '0;
        s0_wdata_d = '0;
        s1_req_d   = 1'b0;
        s1_we_d    = 1'b0;
        s1_addr_d  = '0;
        s1_wdata_d = '0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (addr[1:0] != 2'b00) begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ErrData;
                    end else begin
                        state_d = StWait;
                        cnt_d   = '0;
                        sel_d   = (addr[31:28] == IO_NIBBLE);
                        // The port registers double as the latched request.
                        if (addr[31:28] == IO_NIBBLE) begin
                            s1_req_d   = 1'b1;
                            s1_we_d    = we;
                            s1_addr_d  = addr;
                            s1_wdata_d = wdata;
                        end else begin
                            s0_req_d   = 1'b1;
                            s0_we_d    = we;
                            s0_addr_d  = addr;
                            s0_wdata_d = wdata;
                        end
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                // A target ack takes priority over a timeout in the same cycle.
                if (tgt_ack) begin
                    state_d = StResp;
                    ack_d   = 1'b1;
                    rdata_d = tgt_we ? 32'h0 : tgt_rdata;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = ErrData;
                end else begin
                    s0_req_d   = s0_req;
                    s0_we_d    = s0_we;
                    s0_addr_d  = s0_addr;
                    s0_wdata_d = s0_wdata;
                    s1_req_d   = s1_req;
                    s1_we_d    = s1_we;
                    s1_addr_d  = s1_addr;
                    s1_wdata_d = s1_wdata;
                end
            end
            StResp: begin
                // req still high here is deliberately not sampled.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            rdata    <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            s0_req   <= 1'b0;
            s0_we    <= 1'b0;
            s0_addr  <= '0;
            s0_wdata <= '0;
            s1_req   <= 1'b0;
            s1_we    <= 1'b0;
            s1_addr  <= '0;
            s1_wdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rdata    <= rdata_d;
            ack      <= ack_d;
            err      <= err_d;
            s0_req   <= s0_req_d;
            s0_we    <= s0_we_d;
            s0_addr  <= s0_addr_d;
            s0_wdata <= s0_wdata_d;
            s1_req   <= s1_req_d;
            s1_we    <= s1_we_d;
            s1_addr  <= s1_addr_d;
            s1_wdata <= s1_wdata_d;
        end
    end

endmodule

// File: tb/tb_dbus_demux.sv
// Testbench for dbus_demux: directed accesses checked every cycle against a timing-window model.
module tb_dbus_demux;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack, err;
    logic        s0_req, s0_we, s1_req, s1_we;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [31:0] s0_rdata = '0, s1_rdata = '0;
    logic        s0_ack = 1'b0, s1_ack = 1'b0;

    dbus_demux #(.IO_NIBBLE(4'hF), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_ack(s0_ack),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_ack(s1_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the active access: cycles in which the target request is up, the ack cycle,
    // and what the CPU must see at ack.
    int          w_lo = 1, w_hi = 0, w_ack = -1;
    bit          w_port = 1'b0, w_we = 1'b0, w_err = 1'b0;
    logic [31:0] w_addr = '0, w_wdata = '0, w_rdata = '0;

    int          seen_ack = -100;
    logic [31:0] seen_rdata = '0;
    logic        seen_err = 1'b0;
    bit          in_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            in_w = (cyc >= w_lo) && (cyc <= w_hi);
            chk("s0_req", {31'b0, s0_req}, {31'b0, in_w && !w_port});
            chk("s1_req", {31'b0, s1_req}, {31'b0, in_w && w_port});
            if (in_w && w_port) begin
                chk("s1_we", {31'b0, s1_we}, {31'b0, w_we});
                chk("s1_addr", s1_addr, w_addr);
                chk("s1_wdata", s1_wdata, w_wdata);
                chk("s0_idle", {s0_addr | s0_wdata} | {31'b0, s0_we}, 32'h0);
            end
            if (in_w && !w_port) begin
                chk("s0_we", {31'b0, s0_we}, {31'b0, w_we});
                chk("s0_addr", s0_addr, w_addr);
                chk("s0_wdata", s0_wdata, w_wdata);
                chk("s1_idle", {s1_addr | s1_wdata} | {31'b0, s1_we}, 32'h0);
            end
            chk("ack", {31'b0, ack}, {31'b0, cyc == w_ack});
            if (cyc == w_ack) begin
                chk("err", {31'b0, err}, {31'b0, w_err});
                chk("rdata", rdata, w_rdata);
            end
        end
    end

    // Record what the DUT returned at its last ack.
    always @(posedge clk) begin
        #2;
        if (ack) begin
            seen_ack   = cyc;
            seen_rdata = rdata;
            seen_err   = err;
        end
    end

    // Issue one access at a negedge. k = wait cycles before the target acks (>= TO: never),
    // stray = wait cycle on which the other port pulses ack (-1: none).
    task automatic do_access(input logic [31:0] a, input bit w, input logic [31:0] wd,
                             input int k, input logic [31:0] rd, input int stray,
                             input bit keep, output int n);
        bit aligned;
        req = 1'b1; we = w; addr = a; wdata = wd;
        n = (cyc <= w_ack) ? w_ack + 1 : cyc;
        seen_ack = -100;
        aligned = (a[1:0] == 2'b00);
        w_port = (a[31:28] == 4'hF);
        w_we = w; w_addr = a; w_wdata = wd;
        if (!aligned) begin
            w_lo = 1; w_hi = 0; w_ack = n + 1; w_err = 1'b1; w_rdata = 32'hFFFF_FFFF;
        end else if (k < TO) begin
            w_lo = n + 1; w_hi = n + 1 + k; w_ack = n + 2 + k; w_err = 1'b0;
            w_rdata = w ? 32'h0 : rd;
        end else begin
            w_lo = n + 1; w_hi = n + TO; w_ack = n + 1 + TO; w_err = 1'b1;
            w_rdata = 32'hFFFF_FFFF;
        end
        while (cyc < w_ack) begin
            @(negedge clk);
            s0_ack = 1'b0; s1_ack = 1'b0;
            if (aligned && k < TO && cyc == n + 1 + k) begin
                if (w_port) begin s1_ack = 1'b1; s1_rdata = rd; end
                else begin s0_ack = 1'b1; s0_rdata = rd; end
            end
            if (stray >= 0 && cyc == n + 1 + stray) begin
                if (w_port) begin s0_ack = 1'b1; s0_rdata = 32'hDEAD_0000; end
                else begin s1_ack = 1'b1; s1_rdata = 32'hDEAD_0001; end
            end
        end
        if (!keep) req = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    int n1, n2;

    initial begin
        // Reset state.
        #1 rst = 1'b1;
        #2;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack_err", {30'b0, ack, err}, 32'h0);
        chk("rst_s0", {s0_addr | s0_wdata} | {30'b0, s0_req, s0_we}, 32'h0);
        chk("rst_s1", {s1_addr | s1_wdata} | {30'b0, s1_req, s1_we}, 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // RAM read, target acks on its first request cycle.
        do_access(32'h0000_0040, 1'b0, 32'h0, 0, 32'h1234_5678, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_ram_read", seen_ack - n1, 2);
        chk("ram_rdata", seen_rdata, 32'h1234_5678);
        chk("ram_err", {31'b0, seen_err}, 32'h0);

        // MMIO write, target acks after 3 wait cycles.
        do_access(32'hF000_0004, 1'b1, 32'hA5A5_A5A5, 3, 32'h7777_7777, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_mmio_write", seen_ack - n1, 5);
        chk("mmio_rdata", seen_rdata, 32'h0);

        // Misaligned accesses on both address regions.
        do_access(32'h0000_0002, 1'b0, 32'h0, 0, 32'h0, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_misaligned", seen_ack - n1, 1);
        chk("mis_rdata", seen_rdata, 32'hFFFF_FFFF);
        chk("mis_err", {31'b0, seen_err}, 32'h1);
        do_access(32'hF000_0001, 1'b1, 32'h1, 0, 32'h0, -1, 1'b0, n1);
        idle(1);

        // Timeout: target never acks.
        do_access(32'h0000_0080, 1'b0, 32'h0, 99, 32'h0, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_timeout", seen_ack - n1, TO + 1);
        chk("to_rdata", seen_rdata, 32'hFFFF_FFFF);
        chk("to_err", {31'b0, seen_err}, 32'h1);

        // Ack on the last wait cycle wins over timeout.
        do_access(32'h0000_0084, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_ack_at_limit", seen_ack - n1, TO + 1);
        chk("limit_err", {31'b0, seen_err}, 32'h0);
        chk("limit_rdata", seen_rdata, 32'hCAFE_F00D);

        // Stray acks: in IDLE, and on port 1 during a port-0 access.
        s1_ack = 1'b1; s0_ack = 1'b1;
        @(negedge clk);
        s1_ack = 1'b0; s0_ack = 1'b0;
        idle(2);
        do_access(32'h0000_0044, 1'b0, 32'h0, 4, 32'h0BAD_BEEF, 1, 1'b0, n1);
        idle(1);
        chk_int("lat_stray", seen_ack - n1, 6);
        chk("stray_rdata", seen_rdata, 32'h0BAD_BEEF);

        // Back-to-back: next access presented during the ack cycle.
        do_access(32'hF000_0010, 1'b0, 32'h0, 0, 32'h5555_AAAA, -1, 1'b1, n1);
        do_access(32'h0000_0008, 1'b1, 32'h0102_0304, 1, 32'h0, -1, 1'b0, n2);
        idle(1);
        chk_int("b2b_spacing", n2 - n1, 3);
        chk_int("lat_b2b", seen_ack - n2, 3);

        // Reset in the middle of a WAIT.
        idle(1);
        req = 1'b1; we = 1'b0; addr = 32'h0000_0100; wdata = 32'h0;
        n1 = cyc;
        w_port = 1'b0; w_we = 1'b0; w_addr = 32'h0000_0100; w_wdata = 32'h0;
        w_lo = n1 + 1; w_hi = n1 + TO; w_ack = n1 + 1 + TO; w_err = 1'b1;
        w_rdata = 32'hFFFF_FFFF;
        idle(3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = 1'b0;
        w_lo = 1; w_hi = 0; w_ack = -1;
        #1;
        chk("mid_rst_s0", {s0_addr | s0_wdata} | {30'b0, s0_req, s0_we}, 32'h0);
        chk("mid_rst_cpu", rdata | {30'b0, ack, err}, 32'h0);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        s0_ack = 1'b1; s0_rdata = 32'h1111_2222;
        @(negedge clk);
        s0_ack = 1'b0;
        seen_ack = -100;
        idle(3);
        chk_int("late_ack_ignored", seen_ack, -100);
        do_access(32'h0000_0104, 1'b0, 32'h0, 1, 32'h3333_4444, -1, 1'b0, n1);
        idle(1);
        chk_int("lat_after_rst", seen_ack - n1, 3);
        chk("after_rst_rdata", seen_rdata, 32'h3333_4444);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
